// File: rtl/mips_ctrl_pkg.sv
// Shared control types and constants for the MIPS pipeline sequencer.
// Holds the run-control state encoding plus the load/zero-register encodings used by hazard logic.
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2,
        STEP  = 2'd3
    } state_t;

    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
    localparam logic [4:0] REG_ZERO      = 5'd0;

endpackage

// File: rtl/lu_detect.sv
// Load-use hazard compare between the ID sources and a load's destination in EX.
// Latency: combinational. Backpressure: none; the result drives the stall in pipe_ctrl.
// Writes to $0 never create a hazard since $0 is never written.
module lu_detect
    import mips_ctrl_pkg::*;
(
    input  logic       ex_is_load,
    input  logic       v_idex,
    input  logic       v_ifid,
    input  logic [4:0] ex_rw,
    input  logic [4:0] id_ra,
    input  logic [4:0] id_rb,
    input  logic       id_use_ra,
    input  logic       id_use_rb,
    output logic       lu
);

    logic hit_ra;
    logic hit_rb;

    assign hit_ra = id_use_ra & (id_ra == ex_rw);
    assign hit_rb = id_use_rb & (id_rb == ex_rw);
    assign lu     = ex_is_load & v_idex & v_ifid & (ex_rw != REG_ZERO) & (hit_ra | hit_rb);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: load-use stall, MEM-redirect kill, run/drain/halt/step control. Optional PIPE_CTRL_PERF_EN adds stall/flush counters.
// Latency: enables and flushes are combinational from registered state plus inputs; halted is registered.
// Backpressure: a load-use holds PC and IF/ID for one cycle and injects a bubble into ID/EX.
module pipe_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STEP_W       = 8,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_req,
    input  logic              resume_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_cnt,
    input  logic [4:0]        id_ra,
    input  logic [4:0]        id_rb,
    input  logic              id_use_ra,
    input  logic              id_use_rb,
    input  logic [4:0]        ex_rw,
    input  logic              ex_is_load,
    input  logic              mem_redirect,
    output logic              pc_wr_en,
    output logic              if_id_wr_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              halted,
    output logic              retire
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
`endif
);

    localparam state_t RST_STATE = RESET_HALTED ? HALT : RUN;

    state_t            state, state_nx;
    logic [STEP_W-1:0] target, target_nx;
    logic [STEP_W-1:0] retired, retired_nx;
    logic              v_ifid, v_idex, v_exmem, v_memwr;
    logic [2:0]        inflight;
    logic [STEP_W:0]   step_sum;
    logic [STEP_W:0]   ret_sum;
    logic              lu, stall, fetch_en;

    lu_detect u_lu_detect (
        .ex_is_load (ex_is_load),
        .v_idex     (v_idex),
        .v_ifid     (v_ifid),
        .ex_rw      (ex_rw),
        .id_ra      (id_ra),
        .id_rb      (id_rb),
        .id_use_ra  (id_use_ra),
        .id_use_rb  (id_use_rb),
        .lu         (lu)
    );

    // A redirect outranks the stall: the wrong-path ID instruction must not be held.
    assign stall    = lu & ~mem_redirect;
    assign inflight = {2'b00, v_ifid} + {2'b00, v_idex} + {2'b00, v_exmem} + {2'b00, v_memwr};
    assign step_sum = {1'b0, retired} + {{(STEP_W-2){1'b0}}, inflight};
    assign ret_sum  = {1'b0, retired} + {{STEP_W{1'b0}}, v_memwr};
    assign retire   = v_memwr;
    assign halted   = (state == HALT);

    always_comb begin
        fetch_en = 1'b0;
        case (state)
            RUN:     fetch_en = ~halt_req;   // halt stops fetch in the request cycle
            STEP:    fetch_en = (step_sum < {1'b0, target});
            default: fetch_en = 1'b0;
        endcase
    end

    always_comb begin
        pc_wr_en     = 1'b0;
        if_id_wr_en  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (mem_redirect) begin
            pc_wr_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (lu) begin
            if_id_wr_en = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            pc_wr_en    = fetch_en;
            if_id_flush = ~fetch_en;
        end
    end

    always_comb begin
        state_nx   = state;
        target_nx  = target;
        retired_nx = retired;
        case (state)
            RUN: begin
                if (halt_req) state_nx = DRAIN;
            end
            DRAIN: begin
                if (resume_req)         state_nx = RUN;
                else if (inflight == 0) state_nx = HALT;
            end
            HALT: begin
                if (halt_req) begin
                    state_nx = HALT;
                end else if (step_req && (step_cnt != '0)) begin
                    state_nx   = STEP;
                    target_nx  = step_cnt;
                    retired_nx = '0;
                end else if (resume_req) begin
                    state_nx = RUN;
                end
            end
            STEP: begin
                retired_nx = retired + STEP_W'(v_memwr);
                if (halt_req)                        state_nx = DRAIN;
                else if (ret_sum == {1'b0, target})  state_nx = HALT;
            end
            default: state_nx = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RST_STATE;
            target  <= '0;
            retired <= '0;
            v_ifid  <= 1'b0;
            v_idex  <= 1'b0;
            v_exmem <= 1'b0;
            v_memwr <= 1'b0;
        end else begin
            state   <= state_nx;
            target  <= target_nx;
            retired <= retired_nx;
            v_memwr <= v_exmem;
            v_exmem <= v_idex & ~mem_redirect;
            v_idex  <= v_ifid & ~mem_redirect & ~lu;
            v_ifid  <= stall ? v_ifid : (fetch_en & ~mem_redirect);
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall && !(&stall_cycles))        stall_cycles <= stall_cycles + 32'd1;
            if (mem_redirect && !(&flush_events)) flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a small PC/pipeline-register model follows the DUT's enables and
// a scoreboard queue holds the instruction addresses expected to retire.
module tb_pipe_ctrl;

    localparam int          STEP_W = 8;
    localparam logic [31:0] TGT    = 32'h0000_4000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              halt_req = 1'b0, resume_req = 1'b0, step_req = 1'b0;
    logic [STEP_W-1:0] step_cnt = '0;
    logic [4:0]        id_ra = '0, id_rb = '0, ex_rw = '0;
    logic              id_use_ra = 1'b0, id_use_rb = 1'b0, ex_is_load = 1'b0, mem_redirect = 1'b0;
    logic              pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, ex_mem_flush, halted, retire;

    logic [31:0] tb_pc, if_id_pc, id_ex_pc, ex_mem_pc, mem_wb_pc;
    logic [31:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.STEP_W(STEP_W), .RESET_HALTED(1'b0)) dut (
        .clk(clk), .rst(rst), .halt_req(halt_req), .resume_req(resume_req),
        .step_req(step_req), .step_cnt(step_cnt), .id_ra(id_ra), .id_rb(id_rb),
        .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .ex_rw(ex_rw),
        .ex_is_load(ex_is_load), .mem_redirect(mem_redirect), .pc_wr_en(pc_wr_en),
        .if_id_wr_en(if_id_wr_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .halted(halted), .retire(retire)
    );

    // Environment datapath: PC and the address carried by each pipeline register.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_pc <= 32'h0000_1000;
            if_id_pc <= '0; id_ex_pc <= '0; ex_mem_pc <= '0; mem_wb_pc <= '0;
        end else begin
            if (pc_wr_en)    tb_pc <= mem_redirect ? TGT : tb_pc + 32'd4;
            if (if_id_wr_en) if_id_pc <= tb_pc;
            id_ex_pc  <= if_id_pc;
            ex_mem_pc <= id_ex_pc;
            mem_wb_pc <= ex_mem_pc;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        total++; if (pc_wr_en !== 1'b1)     begin bad++; $display("FAIL reset_pc_wr_en got=%b want=1", pc_wr_en); end
        total++; if (if_id_wr_en !== 1'b1)  begin bad++; $display("FAIL reset_if_id_wr_en got=%b want=1", if_id_wr_en); end
        total++; if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b000)
            begin bad++; $display("FAIL reset_flushes got=%b want=000", {if_id_flush, id_ex_flush, ex_mem_flush}); end
        total++; if (halted !== 1'b0)       begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
        total++; if (retire !== 1'b0)       begin bad++; $display("FAIL reset_retire got=%b want=0", retire); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use;
        repeat (5) tick;
        ex_is_load = 1'b1; ex_rw = 5'd5; id_use_ra = 1'b1; id_ra = 5'd5;
        settle;
        total++; if (pc_wr_en !== 1'b0)    begin bad++; $display("FAIL lu_pc_wr_en got=%b want=0", pc_wr_en); end
        total++; if (if_id_wr_en !== 1'b0) begin bad++; $display("FAIL lu_if_id_wr_en got=%b want=0", if_id_wr_en); end
        total++; if (id_ex_flush !== 1'b1) begin bad++; $display("FAIL lu_id_ex_flush got=%b want=1", id_ex_flush); end
        total++; if (if_id_flush !== 1'b0) begin bad++; $display("FAIL lu_if_id_flush got=%b want=0", if_id_flush); end
        tick;
        ex_rw = 5'd0; id_ra = 5'd0;
        settle;
        total++; if (pc_wr_en !== 1'b1)    begin bad++; $display("FAIL lu_rw0_pc_wr_en got=%b want=1", pc_wr_en); end
        total++; if (id_ex_flush !== 1'b0) begin bad++; $display("FAIL lu_rw0_id_ex_flush got=%b want=0", id_ex_flush); end
        tick;
        ex_is_load = 1'b0; id_use_ra = 1'b0;
        settle;
        tick; settle;
        total++; if (retire !== 1'b0) begin bad++; $display("FAIL lu_bubble_retire got=%b want=0", retire); end
        tick; settle;
        total++; if (retire !== 1'b1) begin bad++; $display("FAIL lu_after_bubble_retire got=%b want=1", retire); end
    endtask

    task automatic test_redirect_lu;
        repeat (5) tick;
        mem_redirect = 1'b1; ex_is_load = 1'b1; ex_rw = 5'd7; id_use_rb = 1'b1; id_rb = 5'd7;
        settle;
        total++; if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b111)
            begin bad++; $display("FAIL redir_flushes got=%b want=111", {if_id_flush, id_ex_flush, ex_mem_flush}); end
        total++; if (pc_wr_en !== 1'b1) begin bad++; $display("FAIL redir_pc_wr_en got=%b want=1", pc_wr_en); end
        tick;
        mem_redirect = 1'b0; ex_is_load = 1'b0; id_use_rb = 1'b0; ex_rw = '0; id_rb = '0;
        settle;
        total++; if (retire !== 1'b1)       begin bad++; $display("FAIL redir_r1_retire got=%b want=1", retire); end
        total++; if (ex_mem_flush !== 1'b0) begin bad++; $display("FAIL redir_r1_ex_mem_flush got=%b want=0", ex_mem_flush); end
        for (int i = 0; i < 3; i++) begin
            tick; settle;
            total++; if (retire !== 1'b0) begin bad++; $display("FAIL redir_killed_retire cyc=%0d got=%b want=0", i, retire); end
        end
        tick; settle;
        total++; if (retire !== 1'b1) begin bad++; $display("FAIL redir_target_retire got=%b want=1", retire); end
        total++; if (mem_wb_pc !== TGT) begin bad++; $display("FAIL redir_target_pc got=%h want=%h", mem_wb_pc, TGT); end
    endtask

    task automatic test_halt;
        logic [31:0] ph, ev;
        int n, rets;
        repeat (6) tick;
        halt_req = 1'b1;
        settle;
        total++; if (pc_wr_en !== 1'b0)    begin bad++; $display("FAIL halt_req_pc_wr_en got=%b want=0", pc_wr_en); end
        total++; if (if_id_flush !== 1'b1) begin bad++; $display("FAIL halt_req_if_id_flush got=%b want=1", if_id_flush); end
        ph = tb_pc;
        exp_q.delete();
        for (int k = 4; k >= 1; k--) exp_q.push_back(ph - 32'(4 * k));
        n = 0; rets = 0;
        do begin
            if (retire) begin
                rets++;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL halt_sb_extra got=%h want=none", mem_wb_pc); end
                else begin
                    ev = exp_q.pop_front();
                    if (mem_wb_pc !== ev) begin bad++; $display("FAIL halt_sb_addr got=%h want=%h", mem_wb_pc, ev); end
                end
            end
            tick;
            halt_req = 1'b0;
            settle;
            n++;
        end while (!halted && n < 20);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_timeout got=%b want=1", halted); end
        total++; if (n != 5)          begin bad++; $display("FAIL halt_latency got=%0d want=5", n); end
        total++; if (rets != 4)       begin bad++; $display("FAIL halt_retires got=%0d want=4", rets); end
        total++; if (tb_pc !== ph)    begin bad++; $display("FAIL halt_pc got=%h want=%h", tb_pc, ph); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL halt_sb_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_step(input logic branch);
        logic [31:0] p, ev, want_pc;
        int t, rets, first_t, last_t, halt_t, extra;
        logic redir_done;
        p = tb_pc;
        total++; if ({halted, pc_wr_en, if_id_flush} !== 3'b101)
            begin bad++; $display("FAIL step_pre_state br=%b got=%b want=101", branch, {halted, pc_wr_en, if_id_flush}); end
        exp_q.delete();
        exp_q.push_back(p);
        exp_q.push_back(p + 32'd4);
        exp_q.push_back(branch ? TGT : p + 32'd8);
        want_pc = branch ? TGT + 32'd4 : p + 32'd12;
        step_req = 1'b1; step_cnt = 8'd3;
        settle;
        t = 0; rets = 0; first_t = -1; last_t = -1; halt_t = -1; redir_done = 1'b0;
        while (halt_t < 0 && t < 60) begin
            tick;
            t++;
            step_req = 1'b0; step_cnt = '0; mem_redirect = 1'b0;
            if (branch && !redir_done && ex_mem_pc == p + 32'd4) begin
                mem_redirect = 1'b1;
                redir_done = 1'b1;
            end
            settle;
            if (retire) begin
                rets++;
                if (first_t < 0) first_t = t;
                last_t = t;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL step_sb_extra br=%b got=%h want=none", branch, mem_wb_pc); end
                else begin
                    ev = exp_q.pop_front();
                    if (mem_wb_pc !== ev) begin bad++; $display("FAIL step_sb_addr br=%b got=%h want=%h", branch, mem_wb_pc, ev); end
                end
            end
            if (halted) halt_t = t;
        end
        mem_redirect = 1'b0;
        total++; if (halt_t < 0)  begin bad++; $display("FAIL step_timeout br=%b got=%0d want=halt", branch, t); end
        total++; if (rets != 3)   begin bad++; $display("FAIL step_retires br=%b got=%0d want=3", branch, rets); end
        total++; if (first_t != 5) begin bad++; $display("FAIL step_first_retire br=%b got=%0d want=5", branch, first_t); end
        total++; if (halt_t != last_t + 1)
            begin bad++; $display("FAIL step_halt_time br=%b got=%0d want=%0d", branch, halt_t, last_t + 1); end
        if (branch) begin
            total++; if (redir_done !== 1'b1) begin bad++; $display("FAIL step_branch_seen got=%b want=1", redir_done); end
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick; settle;
            if (retire) extra++;
        end
        total++; if (extra != 0)       begin bad++; $display("FAIL step_extra_retire br=%b got=%0d want=0", branch, extra); end
        total++; if (halted !== 1'b1)  begin bad++; $display("FAIL step_stay_halted br=%b got=%b want=1", branch, halted); end
        total++; if (tb_pc !== want_pc) begin bad++; $display("FAIL step_final_pc br=%b got=%h want=%h", branch, tb_pc, want_pc); end
    endtask

    task automatic test_requests;
        halt_req = 1'b1; step_req = 1'b1; step_cnt = 8'd2; resume_req = 1'b1;
        settle;
        for (int i = 0; i < 3; i++) begin
            tick; settle;
            total++; if (halted !== 1'b1)   begin bad++; $display("FAIL req_all_halted cyc=%0d got=%b want=1", i, halted); end
            total++; if (pc_wr_en !== 1'b0) begin bad++; $display("FAIL req_all_pc_wr_en cyc=%0d got=%b want=0", i, pc_wr_en); end
        end
        halt_req = 1'b0; resume_req = 1'b0; step_cnt = '0;
        settle;
        tick;
        step_req = 1'b0;
        settle;
        for (int i = 0; i < 3; i++) begin
            tick; settle;
            total++; if ({halted, retire} !== 2'b10) begin bad++; $display("FAIL req_cnt0 cyc=%0d got=%b want=10", i, {halted, retire}); end
        end
        resume_req = 1'b1;
        settle;
        tick;
        resume_req = 1'b0;
        settle;
        total++; if (halted !== 1'b0)   begin bad++; $display("FAIL resume_halted got=%b want=0", halted); end
        total++; if (pc_wr_en !== 1'b1) begin bad++; $display("FAIL resume_pc_wr_en got=%b want=1", pc_wr_en); end
    endtask

    task automatic test_reset_mid_step;
        int n;
        repeat (6) tick;
        halt_req = 1'b1;
        settle;
        n = 0;
        do begin
            tick;
            halt_req = 1'b0;
            settle;
            n++;
        end while (!halted && n < 20);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL rstmid_halt_timeout got=%b want=1", halted); end
        step_req = 1'b1; step_cnt = 8'd3;
        settle;
        tick;
        step_req = 1'b0; step_cnt = '0;
        repeat (4) tick;
        settle;
        total++; if (retire !== 1'b1) begin bad++; $display("FAIL rstmid_pre_retire got=%b want=1", retire); end
        #1 rst = 1'b1;
        #1;
        total++; if (retire !== 1'b0)   begin bad++; $display("FAIL rstmid_async_retire got=%b want=0", retire); end
        total++; if (pc_wr_en !== 1'b1) begin bad++; $display("FAIL rstmid_async_pc_wr_en got=%b want=1", pc_wr_en); end
        total++; if (if_id_flush !== 1'b0) begin bad++; $display("FAIL rstmid_async_if_id_flush got=%b want=0", if_id_flush); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick; settle;
            total++; if ({halted, retire} !== 2'b00) begin bad++; $display("FAIL rstmid_run cyc=%0d got=%b want=00", i, {halted, retire}); end
        end
        repeat (8) tick;
        settle;
        total++; if ({halted, retire} !== 2'b01) begin bad++; $display("FAIL rstmid_freerun got=%b want=01", {halted, retire}); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_load_use;
        test_redirect_lu;
        test_halt;
        test_step(1'b0);
        test_step(1'b1);
        test_requests;
        test_reset_mid_step;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
